// File: rtl/regbank_mux_file_pkg.sv
// regbank_mux_file_pkg
//   Shared defaults and constants for the write-back register bank.
//   - DEF_WIDTH / DEF_DEPTH / DEF_NUM_SRC : default parameter values
//   - WB_SRC_ALU / WB_SRC_MEM             : write-back source indices
//   - ZERO_REG                            : 1 when REGBANK_ZERO_REG_EN is defined
//     (register 0 hardwired to zero), 0 otherwise.
package regbank_mux_file_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 32;
    localparam int DEF_NUM_SRC = 2;

    // Write-back source indices into wr_src
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MEM = 1;

`ifdef REGBANK_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

endpackage

// File: rtl/regbank_mux_file_bus_mux_n.sv
// bus_mux_n
//   Combinational N:1 bus select.
//   Ports:
//     src   in  NUM_SRC*WIDTH  flattened sources; source k = src[k*WIDTH +: WIDTH]
//     sel   in  SEL_W          source index
//     data  out WIDTH          selected source (0 when sel is out of range)
//     legal out 1              sel < NUM_SRC
module bus_mux_n #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 2,
    localparam int SEL_W  = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*WIDTH-1:0] src,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         data,
    output logic                     legal
);

    // A compare loop instead of a variable part-select keeps an out-of-range
    // select well defined (zero data, legal low) when NUM_SRC is not a power of 2.
    always_comb begin
        data  = '0;
        legal = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                data  = src[k*WIDTH +: WIDTH];
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_mux_file.sv
// regbank_mux_file
//   Register bank with NUM_SRC-way write-source select, two registered read
//   ports (latency 1) and same-cycle write-to-read bypass.
//   Optional macro: REGBANK_ZERO_REG_EN -- register 0 reads as zero, writes dropped.
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     wr_en/wr_addr/wr_sel write strobe, destination, source index
//     wr_src               flattened write-back sources
//     rd_en                read strobe for both ports
//     rd_addr_a/b          read addresses
//     rd_data_a/b          registered read data (held while rd_en=0)
//     rd_valid             rd_data_a/b updated this cycle
//     wr_err               sticky illegal-select flag, cleared by reset
module regbank_mux_file
    import regbank_mux_file_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_SRC = DEF_NUM_SRC,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int SEL_W  = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [SEL_W-1:0]         wr_sel,
    input  logic [NUM_SRC*WIDTH-1:0] wr_src,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_a,
    output logic [WIDTH-1:0]         rd_data_b,
    output logic                     rd_valid,
    output logic                     wr_err
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic [WIDTH-1:0] wr_data;
    logic             wr_legal;
    logic             wr_ok;
    logic             wr_commit;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_b;

    bus_mux_n #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC)
    ) u_wr_mux (
        .src   (wr_src),
        .sel   (wr_sel),
        .data  (wr_data),
        .legal (wr_legal)
    );

    // wr_ok drives the bypass; wr_commit additionally drops writes to the
    // hardwired zero register so storage there never changes.
    assign wr_ok     = wr_en && wr_legal;
    assign wr_commit = wr_ok && !(ZERO_REG && (wr_addr == '0));

    always_comb begin
        nxt_a = (wr_ok && (rd_addr_a == wr_addr)) ? wr_data : mem[rd_addr_a];
        nxt_b = (wr_ok && (rd_addr_b == wr_addr)) ? wr_data : mem[rd_addr_b];
        // Zero register wins even over the bypass
        if (ZERO_REG && (rd_addr_a == '0)) nxt_a = '0;
        if (ZERO_REG && (rd_addr_b == '0)) nxt_b = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            if (wr_commit) mem[wr_addr] <= wr_data;
            if (rd_en) begin
                rd_data_a <= nxt_a;
                rd_data_b <= nxt_b;
            end
            rd_valid <= rd_en;
            if (wr_en && !wr_legal) wr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regbank_mux_file.sv
// tb_regbank_mux_file
//   Directed table-driven bench for regbank_mux_file. u_dut uses two sources;
//   u_dut3 uses three sources so an illegal select (3) exists.
//   Honours REGBANK_ZERO_REG_EN for the register-0 expectations.
module tb_regbank_mux_file;

`ifdef REGBANK_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // two-source DUT
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [0:0]  wr_sel;
    logic [63:0] wr_src;
    logic        rd_en;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid, wr_err;

    // three-source DUT
    logic        reset3;
    logic        wr_en3;
    logic [4:0]  wr_addr3;
    logic [1:0]  wr_sel3;
    logic [95:0] wr_src3;
    logic        rd_en3;
    logic [4:0]  rd_addr_a3, rd_addr_b3;
    logic [31:0] rd_data_a3, rd_data_b3;
    logic        rd_valid3, wr_err3;

    regbank_mux_file #(.WIDTH(32), .DEPTH(32), .NUM_SRC(2)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_src(wr_src), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid), .wr_err(wr_err)
    );

    regbank_mux_file #(.WIDTH(32), .DEPTH(32), .NUM_SRC(3)) u_dut3 (
        .clk(clk), .reset(reset3), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_sel(wr_sel3),
        .wr_src(wr_src3), .rd_en(rd_en3), .rd_addr_a(rd_addr_a3), .rd_addr_b(rd_addr_b3),
        .rd_data_a(rd_data_a3), .rd_data_b(rd_data_b3), .rd_valid(rd_valid3), .wr_err(wr_err3)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic        ws;
        logic [31:0] s0;
        logic [31:0] s1;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        ev;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // we wa ws s0 s1 re ra rb | ea eb ev
        vec[0]  = '{1'b1, 5'd5,  1'b1, 32'h0,        32'hDEAD_BEEF, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vec[1]  = '{1'b0, 5'd0,  1'b0, 32'h0,        32'h0,         1'b1, 5'd5,  5'd0,  32'hDEAD_BEEF, 32'h0,       1'b1};
        vec[2]  = '{1'b1, 5'd7,  1'b0, 32'h1234,     32'h9999,      1'b1, 5'd7,  5'd7,  32'h1234,     32'h1234,     1'b1};
        vec[3]  = '{1'b0, 5'd0,  1'b0, 32'h0,        32'h0,         1'b1, 5'd7,  5'd5,  32'h1234,     32'hDEAD_BEEF, 1'b1};
        vec[4]  = '{1'b1, 5'd3,  1'b1, 32'h1111,     32'hAA,        1'b1, 5'd3,  5'd5,  32'hAA,       32'hDEAD_BEEF, 1'b1};
        vec[5]  = '{1'b1, 5'd5,  1'b0, 32'h55,       32'h0,         1'b0, 5'd5,  5'd3,  32'hAA,       32'hDEAD_BEEF, 1'b0};
        vec[6]  = '{1'b0, 5'd0,  1'b0, 32'h0,        32'h0,         1'b0, 5'd1,  5'd2,  32'hAA,       32'hDEAD_BEEF, 1'b0};
        vec[7]  = '{1'b0, 5'd0,  1'b0, 32'h0,        32'h0,         1'b0, 5'd5,  5'd5,  32'hAA,       32'hDEAD_BEEF, 1'b0};
        vec[8]  = '{1'b0, 5'd0,  1'b0, 32'h0,        32'h0,         1'b1, 5'd5,  5'd3,  32'h55,       32'hAA,       1'b1};
        vec[9]  = '{1'b1, 5'd5,  1'b1, 32'h0,        32'h77,        1'b1, 5'd3,  5'd5,  32'hAA,       32'h77,       1'b1};
        vec[10] = '{1'b1, 5'd31, 1'b0, 32'hFFFF_0000, 32'h0,        1'b0, 5'd31, 5'd31, 32'hAA,       32'h77,       1'b0};
        vec[11] = '{1'b0, 5'd0,  1'b0, 32'h0,        32'h0,         1'b1, 5'd31, 5'd9,  32'hFFFF_0000, 32'h0,       1'b1};
        vec[12] = '{1'b1, 5'd0,  1'b1, 32'h0,        32'hFFFF_FFFF, 1'b1, 5'd0,  5'd0,
                    ZR ? 32'h0 : 32'hFFFF_FFFF, ZR ? 32'h0 : 32'hFFFF_FFFF, 1'b1};
        vec[13] = '{1'b0, 5'd0,  1'b0, 32'h0,        32'h0,         1'b1, 5'd0,  5'd5,
                    ZR ? 32'h0 : 32'hFFFF_FFFF, 32'h77, 1'b1};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_sel = '0; wr_src = '0;
        rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        reset3 = 1'b1; wr_en3 = 1'b0; wr_addr3 = '0; wr_sel3 = '0; wr_src3 = '0;
        rd_en3 = 1'b0; rd_addr_a3 = '0; rd_addr_b3 = '0;
        tick; tick;
        check("reset_rd_a", rd_data_a, 32'h0);
        check("reset_rd_b", rd_data_b, 32'h0);
        check("reset_valid", {31'b0, rd_valid}, 32'h0);
        check("reset_err", {31'b0, wr_err}, 32'h0);
        reset = 1'b0;
        reset3 = 1'b0;

        for (int i = 0; i < NV; i++) begin
            wr_en = vec[i].we; wr_addr = vec[i].wa; wr_sel = vec[i].ws;
            wr_src = {vec[i].s1, vec[i].s0};
            rd_en = vec[i].re; rd_addr_a = vec[i].ra; rd_addr_b = vec[i].rb;
            tick;
            check($sformatf("vec%0d_rd_a", i), rd_data_a, vec[i].ea);
            check($sformatf("vec%0d_rd_b", i), rd_data_b, vec[i].eb);
            check($sformatf("vec%0d_valid", i), {31'b0, rd_valid}, {31'b0, vec[i].ev});
        end
        check("no_err_2src", {31'b0, wr_err}, 32'h0);

        // Random writes, then reset held 2 cycles with write/read strobes active
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 5'(8 + i); wr_sel = 1'(i);
            wr_src = {$urandom() | 32'h1, $urandom() | 32'h1};
            rd_en = 1'b0;
            tick;
        end
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; rd_en = 1'b1; rd_addr_a = 5'd9; rd_addr_b = 5'd5;
        tick; tick;
        check("rst2_valid", {31'b0, rd_valid}, 32'h0);
        check("rst2_rd_a", rd_data_a, 32'h0);
        check("rst2_rd_b", rd_data_b, 32'h0);
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
            tick;
            check($sformatf("post_rst_a%0d", i), rd_data_a, 32'h0);
            check($sformatf("post_rst_b%0d", 31 - i), rd_data_b, 32'h0);
        end
        rd_en = 1'b0;

        // Three-source DUT: legal sel 2 with bypass, then illegal sel 3
        wr_en3 = 1'b1; wr_addr3 = 5'd2; wr_sel3 = 2'd2;
        wr_src3 = {32'hCAFE, 32'h2222, 32'h1111};
        rd_en3 = 1'b1; rd_addr_a3 = 5'd2; rd_addr_b3 = 5'd4;
        tick;
        check("s3_bypass_sel2", rd_data_a3, 32'hCAFE);
        check("s3_err_legal", {31'b0, wr_err3}, 32'h0);
        wr_sel3 = 2'd3; wr_src3 = {32'h5555, 32'h6666, 32'h7777};
        tick;
        check("s3_illegal_nobypass", rd_data_a3, 32'hCAFE);
        check("s3_err_set", {31'b0, wr_err3}, 32'h1);
        wr_en3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check($sformatf("s3_reg2_kept%0d", i), rd_data_a3, 32'hCAFE);
            check($sformatf("s3_err_held%0d", i), {31'b0, wr_err3}, 32'h1);
        end
        reset3 = 1'b1;
        tick;
        check("s3_err_cleared", {31'b0, wr_err3}, 32'h0);
        reset3 = 1'b0; rd_en3 = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
